adc3v_sar_ctrl: RTL and testbench

- Clocked successive-approximation controller for the 12-bit 3V ADC analog macro (single channel, adc0).
- Sequences enable, reset, sample/hold and the 12-bit DAC trial code; reads the comparator.
- Returns the converted code to a digital host through a one-entry valid/ready output buffer.
- Sits between the SoC register/bus logic and the analog macro pins.

---
 rtl/adc3v_sar_pkg.sv | 18 +
 rtl/adc3v_sync2.sv | 21 ++
 rtl/adc3v_sar_ctrl.sv | 153 +++++++++++++++
 tb/tb_adc3v_sar_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc3v_sar_pkg.sv
// Shared types and default timing for the 3V SAR ADC controller.
package adc3v_sar_pkg;

    localparam int ADC_BITS = 12;

    localparam int DEF_RESET_CYCLES  = 2;
    localparam int DEF_SAMPLE_CYCLES = 4;
    localparam int DEF_SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SAMPLE,
        CONV,
        DONE
    } sar_state_t;

endpackage

// File: rtl/adc3v_sync2.sv
// Two-flop synchronizer for the asynchronous comparator output.
module adc3v_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc3v_sar_ctrl.sv
// SAR sequencer for the adc0 macro with a one-entry valid/ready result buffer.
module adc3v_sar_ctrl
    import adc3v_sar_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                start,
    input  logic                cont_en,
    output logic                busy,
    output logic [ADC_BITS-1:0] data,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                overrun,
    output logic                adc0_ena,
    output logic                adc0_reset,
    output logic                adc0_hold,
    output logic [ADC_BITS-1:0] adc0_dac_val_0,
    input  logic                adc0_comp_out
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(SETTLE_CYCLES + 1);
    localparam logic [3:0]       MSB_IDX  = 4'(ADC_BITS - 1);

    sar_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          bit_q, bit_d;
    logic [ADC_BITS-1:0] res_q, res_d;
    logic [ADC_BITS-1:0] data_d;
    logic                valid_d, valid_keep, ovr_d;
    logic                ena_d, rst_d, hold_d;
    logic [ADC_BITS-1:0] dac_d;
    logic                comp_s;

    adc3v_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc0_comp_out),
        .q     (comp_s)
    );

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_q          <= '0;
            res_q          <= '0;
            data           <= '0;
            data_valid     <= 1'b0;
            overrun        <= 1'b0;
            adc0_ena       <= 1'b0;
            adc0_reset     <= 1'b0;
            adc0_hold      <= 1'b0;
            adc0_dac_val_0 <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            res_q          <= res_d;
            data           <= data_d;
            data_valid     <= valid_d;
            overrun        <= ovr_d;
            adc0_ena       <= ena_d;
            adc0_reset     <= rst_d;
            adc0_hold      <= hold_d;
            adc0_dac_val_0 <= dac_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        res_d      = res_q;
        data_d     = data;
        valid_keep = data_valid & ~data_ready;
        valid_d    = valid_keep;
        ovr_d      = overrun;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start && enable) begin
                    state_d = RST;
                    ovr_d   = 1'b0;
                end
            end
            RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end
            end
            SAMPLE: begin
                if (cnt_q == SMP_LAST) begin
                    state_d = CONV;
                    cnt_d   = '0;
                    bit_d   = MSB_IDX;
                    res_d   = '0;
                end
            end
            CONV: begin
                // Decide the bit on the last cycle of its phase.
                if (cnt_q == PH_LAST) begin
                    cnt_d        = '0;
                    res_d[bit_q] = comp_s;
                    if (bit_q == 4'd0) state_d = DONE;
                    else               bit_d   = bit_q - 1'b1;
                end
            end
            DONE: begin
                data_d  = res_q;
                valid_d = 1'b1;
                if (valid_keep) ovr_d = 1'b1;
                cnt_d   = '0;
                state_d = (cont_en && enable) ? RST : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort leaves the result buffer untouched.
        if (state_q != IDLE && !enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            data_d  = data;
            valid_d = valid_keep;
            ovr_d   = overrun;
        end
    end

    always_comb begin
        ena_d  = (state_d == IDLE) ? enable : 1'b1;
        rst_d  = (state_d == RST);
        hold_d = (state_d == CONV);
        dac_d  = '0;
        if (state_d == CONV) begin
            dac_d = res_d | (ADC_BITS'(1) << bit_d);
        end
    end

endmodule

// File: tb/tb_adc3v_sar_ctrl.sv
// Scoreboard bench for adc3v_sar_ctrl with an ideal comparator model.
module tb_adc3v_sar_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic        cont_en;
    logic        busy;
    logic [11:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        overrun;
    logic        adc0_ena;
    logic        adc0_reset;
    logic        adc0_hold;
    logic [11:0] adc0_dac_val_0;
    logic        adc0_comp_out;
    logic [11:0] tgt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    assign adc0_comp_out = (adc0_dac_val_0 <= tgt);

    adc3v_sar_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .start          (start),
        .cont_en        (cont_en),
        .busy           (busy),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .overrun        (overrun),
        .adc0_ena       (adc0_ena),
        .adc0_reset     (adc0_reset),
        .adc0_hold      (adc0_hold),
        .adc0_dac_val_0 (adc0_dac_val_0),
        .adc0_comp_out  (adc0_comp_out)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got %0h expected none", data);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("sb_data", {20'd0, data}, {20'd0, e});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        if (busy) check("timeout_idle", 1, 0);
    endtask

    task automatic run_conv(input logic [11:0] t);
        tgt = t;
        exp_q.push_back(t);
        pulse_start();
        wait_idle(100);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        rst_n      = 1'b0;
        enable     = 1'b0;
        start      = 1'b0;
        cont_en    = 1'b0;
        data_ready = 1'b1;
        tgt        = 12'h000;
        #23;
        check("rst_busy", busy, 0);
        check("rst_data", data, 0);
        check("rst_valid", data_valid, 0);
        check("rst_ovr", overrun, 0);
        check("rst_ena", adc0_ena, 0);
        check("rst_reset", adc0_reset, 0);
        check("rst_hold", adc0_hold, 0);
        check("rst_dac", adc0_dac_val_0, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(3);
        check("idle_ena", adc0_ena, 1);

        tgt = 12'hA5C;
        exp_q.push_back(12'hA5C);
        pulse_start();
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (i == 1) check("rst_phase", adc0_reset, 1);
            if (i == 5) check("hold_pre", adc0_hold, 0);
            if (i == 6) check("hold_conv", adc0_hold, 1);
            if (i == 6) check("dac_b11", adc0_dac_val_0, 12'h800);
            if (i == 10) check("dac_b10", adc0_dac_val_0, 12'hC00);
            if (i == 14) check("dac_b9", adc0_dac_val_0, 12'hA00);
            if (i == 18) check("dac_b8", adc0_dac_val_0, 12'hB00);
            if (data_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, 55);
        tick(2);
        check("valid_clear", data_valid, 0);

        run_conv(12'h000);
        run_conv(12'hFFF);

        data_ready = 1'b0;
        cont_en    = 1'b1;
        tgt        = 12'h123;
        pulse_start();
        k = 0;
        while (!data_valid && k < 80) begin
            tick(1);
            k++;
        end
        check("cont_first_valid", data_valid, 1);
        check("cont_first_data", data, 12'h123);
        check("cont_first_ovr", overrun, 0);
        k = 0;
        while (!overrun && k < 80) begin
            tick(1);
            k++;
        end
        check("ovr_set", overrun, 1);
        check("ovr_data", data, 12'h123);
        cont_en = 1'b0;
        wait_idle(100);
        check("ovr_sticky", overrun, 1);
        pulse_start();
        check("ovr_clear", overrun, 0);
        exp_q.push_back(12'h123);
        exp_q.push_back(12'h123);
        data_ready = 1'b1;
        wait_idle(100);
        tick(2);
        check("ovr_after", overrun, 0);

        tgt = 12'h3C3;
        pulse_start();
        tick(10);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("busy_start_reset", adc0_reset, 0);
        check("busy_start_hold", adc0_hold, 1);
        tick(9);
        enable = 1'b0;
        tick(1);
        check("abort_busy", busy, 0);
        check("abort_hold", adc0_hold, 0);
        check("abort_dac", adc0_dac_val_0, 0);
        check("abort_valid", data_valid, 0);
        check("abort_data", data, 12'h123);
        enable = 1'b1;
        tick(3);

        pulse_start();
        tick(15);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ena", adc0_ena, 0);
        check("arst_hold", adc0_hold, 0);
        check("arst_dac", adc0_dac_val_0, 0);
        check("arst_data", data, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        run_conv(12'h555);

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
